// File: rtl/pipe_credit_sink.sv
// pipe_credit_sink: receive-side endpoint of a credit-controlled, non-stallable pipe.
// Beats arriving on in_valid/in_data are buffered in a DEPTH-entry FIFO and
// presented downstream first-word-fall-through with valid/ready. Every dequeue
// returns one credit upstream as a registered one-cycle pulse on credit_out.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   in_valid   beat arriving from upstream this cycle (no backpressure)
//   in_data    arriving payload
//   out_valid  buffer non-empty
//   out_data   head-of-queue payload (don't-care while out_valid=0)
//   out_ready  downstream accepts the head entry
//   credit_out one-cycle pulse per dequeue, one cycle after the dequeue
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: a beat arrived while full with no dequeue (dropped)
module pipe_credit_sink #(
    parameter int unsigned DATAW = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic             out_ready,
    output logic             credit_out,
    output logic [CNTW-1:0]  count,
    output logic             overflow
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTRW-1:0] LastPtr = PTRW'(DEPTH - 1);
    localparam logic [CNTW-1:0] FullCnt = CNTW'(DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wptr;
    logic [PTRW-1:0]  rptr;
    logic [PTRW-1:0]  wptr_next;
    logic [PTRW-1:0]  rptr_next;
    logic             full;
    logic             deq;
    logic             enq;
    logic             drop;

    always_comb begin
        full      = (count == FullCnt);
        out_valid = (count != '0);
        out_data  = mem[rptr];
        deq       = out_valid & out_ready;
        // A dequeue in the same cycle frees the slot, so a full buffer still accepts.
        enq       = in_valid & (~full | deq);
        drop      = in_valid & full & ~deq;
        // Explicit wrap so non-power-of-2 depths work.
        wptr_next = (wptr == LastPtr) ? '0 : wptr + PTRW'(1);
        rptr_next = (rptr == LastPtr) ? '0 : rptr + PTRW'(1);
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            credit_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (enq) begin
                wptr <= wptr_next;
            end
            if (deq) begin
                rptr <= rptr_next;
            end
            if (enq && !deq) begin
                count <= count + CNTW'(1);
            end else if (deq && !enq) begin
                count <= count - CNTW'(1);
            end
            credit_out <= deq;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= FullCnt)
                else $error("count exceeds DEPTH");
            if (out_valid) begin
                assert (!$isunknown(out_data))
                    else $error("out_data unknown while out_valid");
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset) $rose(overflow) |-> $past(drop))
        else $error("overflow rose without a drop");
`endif

endmodule

// File: tb/tb_pipe_credit_sink.sv
// Directed self-checking bench for pipe_credit_sink. Instance a uses DEPTH=4,
// instance b uses DEPTH=3 to exercise non-power-of-2 pointer wrap.
module tb_pipe_credit_sink;

    logic        clk;
    logic        reset;

    logic        a_in_valid;
    logic [31:0] a_in_data;
    logic        a_out_valid;
    logic [31:0] a_out_data;
    logic        a_out_ready;
    logic        a_credit;
    logic [2:0]  a_count;
    logic        a_overflow;

    logic        b_in_valid;
    logic [7:0]  b_in_data;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic        b_out_ready;
    logic        b_credit;
    logic [1:0]  b_count;
    logic        b_overflow;

    int checks;
    int failures;

    pipe_credit_sink #(.DATAW(32), .DEPTH(4)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (a_in_valid),
        .in_data    (a_in_data),
        .out_valid  (a_out_valid),
        .out_data   (a_out_data),
        .out_ready  (a_out_ready),
        .credit_out (a_credit),
        .count      (a_count),
        .overflow   (a_overflow)
    );

    pipe_credit_sink #(.DATAW(8), .DEPTH(3)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (b_in_valid),
        .in_data    (b_in_data),
        .out_valid  (b_out_valid),
        .out_data   (b_out_data),
        .out_ready  (b_out_ready),
        .credit_out (b_credit),
        .count      (b_count),
        .overflow   (b_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (a_count !== 3'd0) begin failures++;
            $display("FAIL reset_a_count got=%0d exp=0", a_count); end
        checks++; if (a_out_valid !== 1'b0) begin failures++;
            $display("FAIL reset_a_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_credit !== 1'b0 || a_overflow !== 1'b0) begin failures++;
            $display("FAIL reset_a_flags credit=%b ovf=%b exp=0,0", a_credit, a_overflow); end
        checks++; if (b_count !== 2'd0 || b_out_valid !== 1'b0 || b_credit !== 1'b0
                      || b_overflow !== 1'b0) begin failures++;
            $display("FAIL reset_b got cnt=%0d v=%b c=%b o=%b exp=0,0,0,0",
                     b_count, b_out_valid, b_credit, b_overflow); end
        reset = 1'b0;
    endtask

    task automatic test_fill3();
        logic [31:0] exp_data;
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            exp_data   = 32'h11 * (i + 1);
            a_in_data  = exp_data;
            step();
            checks++; if (a_credit !== 1'b0) begin failures++;
                $display("FAIL fill3_credit beat=%0d got=%b exp=0", i, a_credit); end
        end
        a_in_valid = 1'b0;
        a_in_data  = 32'h0;
        checks++; if (a_count !== 3'd3) begin failures++;
            $display("FAIL fill3_count got=%0d exp=3", a_count); end
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h11) begin failures++;
            $display("FAIL fill3_head got v=%b d=%h exp v=1 d=00000011",
                     a_out_valid, a_out_data); end
    endtask

    task automatic test_drain3();
        logic [31:0] exp_data;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_data = 32'h11 * (i + 1);
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp_data) begin failures++;
                $display("FAIL drain3_data idx=%0d got v=%b d=%h exp v=1 d=%h",
                         i, a_out_valid, a_out_data, exp_data); end
            step();
            checks++; if (a_credit !== 1'b1) begin failures++;
                $display("FAIL drain3_credit idx=%0d got=%b exp=1", i, a_credit); end
        end
        a_out_ready = 1'b0;
        checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin failures++;
            $display("FAIL drain3_empty got cnt=%0d v=%b exp 0,0", a_count, a_out_valid); end
        step();
        checks++; if (a_credit !== 1'b0) begin failures++;
            $display("FAIL drain3_credit_end got=%b exp=0", a_credit); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_data;
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'hA0 + i;
            step();
        end
        checks++; if (a_count !== 3'd4 || a_overflow !== 1'b0) begin failures++;
            $display("FAIL ovf_full got cnt=%0d o=%b exp 4,0", a_count, a_overflow); end
        a_in_data = 32'hFF;
        step();
        a_in_valid = 1'b0;
        checks++; if (a_overflow !== 1'b1 || a_count !== 3'd4) begin failures++;
            $display("FAIL ovf_drop got o=%b cnt=%0d exp 1,4", a_overflow, a_count); end
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_data = 32'hA0 + i;
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp_data) begin failures++;
                $display("FAIL ovf_drain idx=%0d got v=%b d=%h exp v=1 d=%h",
                         i, a_out_valid, a_out_data, exp_data); end
            step();
        end
        a_out_ready = 1'b0;
        checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0 || a_overflow !== 1'b1)
            begin failures++;
            $display("FAIL ovf_after got cnt=%0d v=%b o=%b exp 0,0,1",
                     a_count, a_out_valid, a_overflow); end
        step();
    endtask

    task automatic test_full_simul();
        logic [31:0] exp_q [4];
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (a_overflow !== 1'b0) begin failures++;
            $display("FAIL simul_reset_ovf got=%b exp=0", a_overflow); end
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h60 + i;
            step();
        end
        a_in_data   = 32'h55;
        a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        checks++; if (a_count !== 3'd4 || a_overflow !== 1'b0) begin failures++;
            $display("FAIL simul_full got cnt=%0d o=%b exp 4,0", a_count, a_overflow); end
        exp_q[0] = 32'h61;
        exp_q[1] = 32'h62;
        exp_q[2] = 32'h63;
        exp_q[3] = 32'h55;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp_q[i]) begin failures++;
                $display("FAIL simul_drain idx=%0d got v=%b d=%h exp v=1 d=%h",
                         i, a_out_valid, a_out_data, exp_q[i]); end
            step();
        end
        a_out_ready = 1'b0;
        checks++; if (a_count !== 3'd0) begin failures++;
            $display("FAIL simul_empty got cnt=%0d exp=0", a_count); end
        step();
    endtask

    task automatic test_stream_depth3();
        int credits;
        logic [7:0] exp_data;
        credits = 0;
        b_out_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            b_in_valid = (i < 10);
            b_in_data  = 8'(i);
            if (i >= 1) begin
                exp_data = 8'(i - 1);
                checks++; if (b_out_valid !== 1'b1 || b_out_data !== exp_data) begin
                    failures++;
                    $display("FAIL stream_data idx=%0d got v=%b d=%0d exp v=1 d=%0d",
                             i - 1, b_out_valid, b_out_data, exp_data); end
            end
            step();
            if (b_credit === 1'b1) credits++;
            checks++; if (b_count > 2'd1) begin failures++;
                $display("FAIL stream_count cyc=%0d got=%0d exp<=1", i, b_count); end
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        checks++; if (credits != 10) begin failures++;
            $display("FAIL stream_credits got=%0d exp=10", credits); end
        checks++; if (b_count !== 2'd0 || b_out_valid !== 1'b0) begin failures++;
            $display("FAIL stream_end got cnt=%0d v=%b exp 0,0", b_count, b_out_valid); end
        step();
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h1 + i;
            step();
        end
        a_in_valid = 1'b0;
        checks++; if (a_count !== 3'd2) begin failures++;
            $display("FAIL rstmid_pre got cnt=%0d exp=2", a_count); end
        reset       = 1'b1;
        a_out_ready = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0 || a_credit !== 1'b0)
            begin failures++;
            $display("FAIL rstmid_flush got cnt=%0d v=%b c=%b exp 0,0,0",
                     a_count, a_out_valid, a_credit); end
        step();
        checks++; if (a_credit !== 1'b0 || a_count !== 3'd0) begin failures++;
            $display("FAIL rstmid_after got c=%b cnt=%0d exp 0,0", a_credit, a_count); end
        a_out_ready = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        a_in_valid  = 1'b0;
        a_in_data   = 32'h0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = 8'h0;
        b_out_ready = 1'b0;
        test_reset();
        test_fill3();
        test_drain3();
        test_overflow();
        test_full_simul();
        test_stream_depth3();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
